disp_rd_buf: RTL



---
 rtl/disp_pkg.sv | 18 +
 rtl/disp_sync_fifo.sv | 67 ++++++
 rtl/disp_rd_buf.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the display read buffer.
// Defaults describe a 320x240 RGB565 frame held in SDRAM.
package disp_pkg;
    localparam int DISP_DW          = 16;
    localparam int DISP_AW          = 22;
    localparam int DISP_DEPTH       = 64;
    localparam int DISP_BURST_LEN   = 8;
    localparam int DISP_FRAME_BASE  = 0;
    localparam int DISP_FRAME_WORDS = 76800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_FLUSH,
        S_DONE
    } rd_state_e;
endpackage

// File: rtl/disp_sync_fifo.sv
// Purpose: single-clock RAM FIFO with synchronous clear and registered read port.
// Latency: rddb valid one cycle after a pop is sampled; a write is visible in usedw next cycle.
// Backpressure: writes while full are dropped, pops while empty (or during clr) are ignored.
module disp_sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [DW-1:0]            wr_dat,
    input  logic                     rd,
    output logic [DW-1:0]            rddb,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] rddb_q, rddb_d;
    logic          wr_en, rd_en;

    assign usedw = wr_ptr_q - rd_ptr_q;
    assign empty = (usedw == '0);
    assign full  = (usedw == (PW+1)'(DEPTH));
    assign rddb  = rddb_q;

    // Emptiness is judged before this cycle's write, so a pop racing the first write is refused.
    assign wr_en = wr & ~clr & ~full;
    assign rd_en = rd & ~clr & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rddb_d   = rddb_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + (PW+1)'(1);
                rddb_d   = mem[rd_ptr_q[PW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[PW-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rddb_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rddb_q   <= rddb_d;
        end
    end
endmodule

// File: rtl/disp_rd_buf.sv
// Purpose: keeps the LCD pixel FIFO topped up by walking the frame buffer in fixed SDRAM bursts.
// Latency: rddb one cycle after a sampled pop; a new request one cycle after space opens up.
// Backpressure: a burst is requested only when it fits; sdr_rd_req is held until sdr_rd_ack.
module disp_rd_buf
    import disp_pkg::*;
#(
    parameter int DW          = DISP_DW,
    parameter int AW          = DISP_AW,
    parameter int DEPTH       = DISP_DEPTH,
    parameter int BURST_LEN   = DISP_BURST_LEN,
    parameter int FRAME_BASE  = DISP_FRAME_BASE,
    parameter int FRAME_WORDS = DISP_FRAME_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdfifo_clr,
    input  logic                     rdfifo_rdreq,
    output logic [DW-1:0]            rdfifo_rddb,
    output logic                     sdr_rd_req,
    output logic [AW-1:0]            sdr_rd_addr,
    input  logic                     sdr_rd_ack,
    input  logic                     sdr_rd_valid,
    input  logic [DW-1:0]            sdr_rd_data,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(BURST_LEN) + 1;

    // One extra address bit so a frame ending exactly at 2^AW still compares correctly.
    localparam logic [AW:0]   ADDR_BASE = (AW+1)'(FRAME_BASE);
    localparam logic [AW:0]   ADDR_END  = (AW+1)'(FRAME_BASE + FRAME_WORDS);
    localparam logic [AW:0]   ADDR_STEP = (AW+1)'(BURST_LEN);
    localparam logic [PW:0]   FILL_MAX  = (PW+1)'(DEPTH - BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    rd_state_e     state_q, state_d;
    logic [AW:0]   fetch_addr_q, fetch_addr_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          underflow_q, underflow_d;

    logic          fifo_wr, fifo_empty, fifo_full;
    logic [AW:0]   addr_inc;

    assign addr_inc = fetch_addr_q + ADDR_STEP;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        fifo_wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rdfifo_clr && (fetch_addr_q < ADDR_END) && (usedw <= FILL_MAX)) begin
                    req_addr_d   = fetch_addr_q[AW-1:0];
                    flush_pend_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                // A request cannot be withdrawn; remember the clear and drop its data later.
                if (rdfifo_clr) flush_pend_d = 1'b1;
                if (sdr_rd_ack) state_d = (rdfifo_clr || flush_pend_q) ? S_FLUSH : S_DATA;
            end
            S_DATA: begin
                if (sdr_rd_valid) begin
                    fifo_wr = ~fifo_full;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d   = '0;
                        fetch_addr_d = addr_inc;
                        state_d      = (addr_inc == ADDR_END) ? S_DONE : S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                        if (rdfifo_clr) state_d = S_FLUSH;
                    end
                end else if (rdfifo_clr) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (sdr_rd_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // Frame restart overrides the burst bookkeeping above; a finished frame rearms here.
        if (rdfifo_clr) begin
            fetch_addr_d = ADDR_BASE;
            if (state_d == S_DONE) state_d = S_IDLE;
        end
    end

    assign underflow_d = rdfifo_clr ? 1'b0 : (underflow_q | (rdfifo_rdreq & fifo_empty));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= ADDR_BASE;
            req_addr_q   <= ADDR_BASE[AW-1:0];
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            underflow_q  <= underflow_d;
        end
    end

    assign sdr_rd_req  = (state_q == S_REQ);
    assign sdr_rd_addr = req_addr_q;
    assign underflow   = underflow_q;

    disp_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (rdfifo_clr),
        .wr     (fifo_wr),
        .wr_dat (sdr_rd_data),
        .rd     (rdfifo_rdreq),
        .rddb   (rdfifo_rddb),
        .usedw  (usedw),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );
endmodule
